// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared constants and types for the multi-port register file.
//               Holds the default width/depth and the register-address and
//               data-word typedefs at default sizing.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int DEF_BITSIZE = 32;
    localparam int DEF_REGS    = 32;
    localparam int DEF_AW      = $clog2(DEF_REGS);

    typedef logic [DEF_AW-1:0]      reg_addr_t;
    typedef logic [DEF_BITSIZE-1:0] data_word_t;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : regfile_scoreboard
// Description : Per-register busy bits for hazard detection.
//               Per-cycle priority: flush clears everything (reserve ignored),
//               otherwise a reserve sets its bit and enabled writes clear
//               theirs; a reserve wins over a write on the same register.
//               Register 0 is never marked busy.
// Ports       : clk, rstn_i      - clock, async active-low reset
//               rsv_i/rsv_addr_i - reserve request and target register
//               flush_i          - clear all busy bits
//               we_i/waddr_i     - write-port enables and flat addresses
//               busy_o           - busy vector, one bit per register
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_scoreboard #(
    parameter  int REGS     = 32,
    parameter  int NR_WRITE = 2,
    localparam int AW       = $clog2(REGS)
) (
    input  logic                   clk,
    input  logic                   rstn_i,
    input  logic                   rsv_i,
    input  logic [AW-1:0]          rsv_addr_i,
    input  logic                   flush_i,
    input  logic [NR_WRITE-1:0]    we_i,
    input  logic [NR_WRITE*AW-1:0] waddr_i,
    output logic [REGS-1:0]        busy_o
);

    logic [REGS-1:0] r_busy;
    logic [REGS-1:0] w_busy_nxt;

    always_comb begin
        w_busy_nxt = r_busy;
        for (int i = 0; i < REGS; i++) begin
            // Clear first so a same-cycle reserve overrides the retiring write.
            for (int k = 0; k < NR_WRITE; k++) begin
                if (we_i[k] && (waddr_i[k*AW +: AW] == AW'(i))) begin
                    w_busy_nxt[i] = 1'b0;
                end
            end
            if (rsv_i && (rsv_addr_i == AW'(i))) begin
                w_busy_nxt[i] = 1'b1;
            end
        end
        if (flush_i) begin
            w_busy_nxt = '0;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign busy_o = r_busy;

endmodule : regfile_scoreboard
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module      : regfile_mp
// Description : Parametrised multi-port register file with a busy scoreboard.
//               Clocked writes (highest write port wins on address clash),
//               combinational reads, register 0 hardwired to zero.
//               Optional feature macro: REGFILE_BYPASS_EN - forwards
//               same-cycle write data (and busy state) onto matching reads.
// Ports       : clk, rstn_i             - clock, async active-low reset
//               raddr_i/rdata_o/rbusy_o - NR_READ flat read ports
//               we_i/waddr_i/wdata_i    - NR_WRITE flat write ports
//               rsv_i/rsv_addr_i        - reserve a register (mark busy)
//               flush_i                 - clear all busy bits
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_mp
    import regfile_pkg::*;
#(
    parameter  int BITSIZE  = DEF_BITSIZE,
    parameter  int REGS     = DEF_REGS,
    parameter  int NR_READ  = 2,
    parameter  int NR_WRITE = 2,
    localparam int AW       = $clog2(REGS)
) (
    input  logic                        clk,
    input  logic                        rstn_i,
    input  logic [NR_READ*AW-1:0]       raddr_i,
    output logic [NR_READ*BITSIZE-1:0]  rdata_o,
    output logic [NR_READ-1:0]          rbusy_o,
    input  logic [NR_WRITE-1:0]         we_i,
    input  logic [NR_WRITE*AW-1:0]      waddr_i,
    input  logic [NR_WRITE*BITSIZE-1:0] wdata_i,
    input  logic                        rsv_i,
    input  logic [AW-1:0]               rsv_addr_i,
    input  logic                        flush_i
);

    logic [BITSIZE-1:0] r_mem [REGS];
    logic [REGS-1:0]    w_we;
    logic [BITSIZE-1:0] w_wd  [REGS];
    logic [REGS-1:0]    w_busy;

    // Per-register write select; ascending port scan lets the highest
    // matching port overwrite lower ones. Register 0 is never enabled.
    always_comb begin
        for (int i = 0; i < REGS; i++) begin
            w_we[i] = 1'b0;
            w_wd[i] = '0;
            for (int k = 0; k < NR_WRITE; k++) begin
                if (we_i[k] && (i != 0) && (waddr_i[k*AW +: AW] == AW'(i))) begin
                    w_we[i] = 1'b1;
                    w_wd[i] = wdata_i[k*BITSIZE +: BITSIZE];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < REGS; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < REGS; i++) begin
                if (w_we[i]) begin
                    r_mem[i] <= w_wd[i];
                end
            end
        end
    end

    regfile_scoreboard #(
        .REGS     (REGS),
        .NR_WRITE (NR_WRITE)
    ) u_scoreboard (
        .clk        (clk),
        .rstn_i     (rstn_i),
        .rsv_i      (rsv_i),
        .rsv_addr_i (rsv_addr_i),
        .flush_i    (flush_i),
        .we_i       (we_i),
        .waddr_i    (waddr_i),
        .busy_o     (w_busy)
    );

    for (genvar j = 0; j < NR_READ; j++) begin : g_rd
        logic [AW-1:0]      w_ra;
        logic [BITSIZE-1:0] w_rd;
        logic               w_rb;

        assign w_ra = raddr_i[j*AW +: AW];

        always_comb begin
            w_rd = r_mem[w_ra];
            w_rb = w_busy[w_ra];
`ifdef REGFILE_BYPASS_EN
            // Forward in-flight write data; a matching write retires the
            // producer unless a new reservation lands on the same register.
            for (int k = 0; k < NR_WRITE; k++) begin
                if (we_i[k] && (waddr_i[k*AW +: AW] == w_ra)) begin
                    w_rd = wdata_i[k*BITSIZE +: BITSIZE];
                    w_rb = rsv_i && !flush_i && (rsv_addr_i == w_ra);
                end
            end
`endif
            // Address 0 and an asserted reset both force a quiet read.
            if ((w_ra == '0) || !rstn_i) begin
                w_rd = '0;
                w_rb = 1'b0;
            end
        end

        assign rdata_o[j*BITSIZE +: BITSIZE] = w_rd;
        assign rbusy_o[j]                    = w_rb;
    end

endmodule : regfile_mp
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_mp
// Description : Directed self-checking bench for regfile_mp at default
//               parameters (32 x 32 bits, 2 read ports, 2 write ports).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_mp;

    logic        clk;
    logic        rstn_i;
    logic [9:0]  raddr_i;
    logic [63:0] rdata_o;
    logic [1:0]  rbusy_o;
    logic [1:0]  we_i;
    logic [9:0]  waddr_i;
    logic [63:0] wdata_i;
    logic        rsv_i;
    logic [4:0]  rsv_addr_i;
    logic        flush_i;

    int errors = 0;
    int checks = 0;

    regfile_mp u_dut (
        .clk        (clk),
        .rstn_i     (rstn_i),
        .raddr_i    (raddr_i),
        .rdata_o    (rdata_o),
        .rbusy_o    (rbusy_o),
        .we_i       (we_i),
        .waddr_i    (waddr_i),
        .wdata_i    (wdata_i),
        .rsv_i      (rsv_i),
        .rsv_addr_i (rsv_addr_i),
        .flush_i    (flush_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        we_i    = '0;
        waddr_i = '0;
        wdata_i = '0;
        rsv_i   = 1'b0;
        rsv_addr_i = '0;
        flush_i = 1'b0;
    endtask

    task automatic wr(input int k, input logic [4:0] a, input logic [31:0] d);
        we_i[k]            = 1'b1;
        waddr_i[k*5 +: 5]  = a;
        wdata_i[k*32 +: 32] = d;
    endtask

    task automatic rsv(input logic [4:0] a);
        rsv_i      = 1'b1;
        rsv_addr_i = a;
    endtask

    task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
        raddr_i = {a1, a0};
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        raddr_i = '0;
        rstn_i  = 1'b0;

        // Writes and reservations during reset must be ignored.
        wr(0, 5'd3, 32'h1234_5678);
        wr(1, 5'd28, 32'h8765_4321);
        rsv(5'd3);
        for (int a = 0; a < 32; a++) begin
            rd(5'(a), 5'(31 - a));
            chk("rst_rdata0", rdata_o[31:0],  32'h0);
            chk("rst_rdata1", rdata_o[63:32], 32'h0);
            chk("rst_rbusy",  {30'h0, rbusy_o}, 32'h0);
        end
        idle();
        step();
        rstn_i = 1'b1;
        rd(5'd3, 5'd28);
        chk("post_rst_r3",  rdata_o[31:0],  32'h0);
        chk("post_rst_r28", rdata_o[63:32], 32'h0);
        chk("post_rst_busy", {30'h0, rbusy_o}, 32'h0);

        // Commit a value to r5, then reset in the middle of a new write.
        step();
        wr(0, 5'd5, 32'h0000_1234);
        step();
        idle();
        rd(5'd5, 5'd0);
        chk("r5_write", rdata_o[31:0], 32'h0000_1234);
        step();
        wr(0, 5'd5, 32'hDEAD_BEEF);
        #2;
        rstn_i = 1'b0;
        #1;
        chk("r5_async_clear", rdata_o[31:0], 32'h0);
        step();
        idle();
        rstn_i = 1'b1;
        rd(5'd5, 5'd5);
        chk("r5_after_midrst", rdata_o[31:0], 32'h0);

        // r0 write and reserve have no effect.
        step();
        wr(0, 5'd0, 32'hFFFF_FFFF);
        wr(1, 5'd0, 32'hFFFF_FFFF);
        rsv(5'd0);
        step();
        idle();
        rd(5'd0, 5'd0);
        chk("r0_data",  rdata_o[31:0], 32'h0);
        chk("r0_busy",  {30'h0, rbusy_o}, 32'h0);

        // Same-address writes: highest port wins. Distinct addresses both land.
        step();
        wr(0, 5'd7, 32'h11);
        wr(1, 5'd7, 32'h22);
        step();
        idle();
        rd(5'd7, 5'd7);
        chk("r7_port1_wins", rdata_o[31:0], 32'h22);
        step();
        wr(0, 5'd8, 32'h33);
        wr(1, 5'd31, 32'h44);
        step();
        idle();
        rd(5'd8, 5'd31);
        chk("r8_port0", rdata_o[31:0],  32'h33);
        chk("r31_port1", rdata_o[63:32], 32'h44);

        // Reserve r3; write+reserve keeps it busy; plain write clears it.
        step();
        rsv(5'd3);
        step();
        idle();
        rd(5'd3, 5'd8);
        chk("r3_busy_set",  {30'h0, rbusy_o}, 32'h1);
        step();
        wr(0, 5'd3, 32'h55);
        rsv(5'd3);
        step();
        idle();
        rd(5'd3, 5'd3);
        chk("r3_data_55",      rdata_o[31:0], 32'h55);
        chk("r3_busy_held",    {30'h0, rbusy_o}, 32'h3);
        step();
        wr(1, 5'd3, 32'h66);
        step();
        idle();
        rd(5'd3, 5'd3);
        chk("r3_data_66",      rdata_o[31:0], 32'h66);
        chk("r3_busy_cleared", {30'h0, rbusy_o}, 32'h0);

        // Busy on r1, r2, r4; flush with a simultaneous reserve of r6.
        step();
        rsv(5'd1);
        step();
        rsv(5'd2);
        step();
        rsv(5'd4);
        step();
        idle();
        rd(5'd1, 5'd2);
        chk("busy_r1_r2", {30'h0, rbusy_o}, 32'h3);
        rd(5'd4, 5'd6);
        chk("busy_r4_not_r6", {30'h0, rbusy_o}, 32'h1);
        flush_i = 1'b1;
        rsv(5'd6);
        step();
        idle();
        rd(5'd1, 5'd2);
        chk("flush_r1_r2", {30'h0, rbusy_o}, 32'h0);
        rd(5'd4, 5'd6);
        chk("flush_r4_r6", {30'h0, rbusy_o}, 32'h0);

        // Bypass behaviour on read port 1 with r9 busy and holding 0x1.
        step();
        wr(0, 5'd9, 32'h0000_0001);
        rsv(5'd9);
        step();
        idle();
        wr(1, 5'd9, 32'hA5A5_A5A5);
        rd(5'd0, 5'd9);
`ifdef REGFILE_BYPASS_EN
        chk("bypass_same_cycle_data", rdata_o[63:32], 32'hA5A5_A5A5);
        chk("bypass_same_cycle_busy", {31'h0, rbusy_o[1]}, 32'h0);
`else
        chk("nobypass_old_data", rdata_o[63:32], 32'h0000_0001);
        chk("nobypass_old_busy", {31'h0, rbusy_o[1]}, 32'h1);
`endif
        step();
        idle();
        rd(5'd0, 5'd9);
        chk("r9_committed", rdata_o[63:32], 32'hA5A5_A5A5);
        chk("r9_busy_clear", {31'h0, rbusy_o[1]}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_regfile_mp
`default_nettype wire
